icache_responder: RTL and testbench

Instruction-side responder that serves the fetch stage's instruction requests. Direct-mapped and read-only; a hit returns the instruction one cycle after the request. On a miss it refills the full line from backing memory through a request/beat handshake, then answers the fetch request. It sits between fetch and the unified memory port. Fetch redirects (jumps, branches) cancel any response still in flight.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_line_store.sv | 49 ++++
 rtl/icache_responder.sv | 166 ++++++++++++++++
 tb/tb_icache_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the instruction-side responder.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int off_w(input int words);
    return $clog2(words) + 2;
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - idx_w(lines) - off_w(words);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: word array with registered read, tag array and
// per-line valid bits that can be cleared in one cycle.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 24,
  parameter int IDX_W = $clog2(LINES),
  parameter int WRD_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_index,
  output logic             lk_valid,
  output logic [TAG_W-1:0] lk_tag,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [WRD_W-1:0] rd_word,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WRD_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             tag_wr_en,
  input  logic [TAG_W-1:0] tag_wr,
  input  logic             clr_all
);

  logic [31:0]      data_mem [LINES*WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid;

  assign lk_valid = valid[lk_index];
  assign lk_tag   = tag_mem[lk_index];

  always_ff @(posedge clk) begin
    if (wr_en)     data_mem[{wr_index, wr_word}] <= wr_data;
    if (tag_wr_en) tag_mem[wr_index] <= tag_wr;
    if (rd_en)     rd_data <= data_mem[{rd_index, rd_word}];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           valid <= '0;
    else if (clr_all)   valid <= '0;
    else if (tag_wr_en) valid[wr_index] <= 1'b1;
  end

endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction responder: one-cycle hits, line refill
// over a request/beat handshake on misses, flush and fence.i handling.
module icache_responder
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  input  logic              inval,
  output logic              resp_valid,
  output logic [31:0]       resp_instr,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int IDX_W = idx_w(LINES);
  localparam int WRD_W = $clog2(WORDS);
  localparam int OFF_W = off_w(WORDS);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
  localparam logic [WRD_W-1:0] LAST_BEAT = WRD_W'(WORDS - 1);

  state_e            state;
  logic [ADDR_W-1:0] pend_addr;
  logic [WRD_W-1:0]  beat_cnt;
  logic              flushed;
  logic              inval_pend;
  logic              resp_valid_p1;
  logic              use_rd_p1;

  logic             lk_valid, rd_en, wr_en, tag_wr_en, clr_all;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] rd_index;
  logic [WRD_W-1:0] rd_word;
  logic [31:0]      rd_data;

  logic [IDX_W-1:0] req_idx, pend_idx;
  logic [WRD_W-1:0] req_word, pend_word;
  logic [TAG_W-1:0] req_tag, pend_tag;
  logic             accept, misaligned, hit;

  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_word  = req_addr[2 +: WRD_W];
  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign pend_idx  = pend_addr[OFF_W +: IDX_W];
  assign pend_word = pend_addr[2 +: WRD_W];
  assign pend_tag  = pend_addr[ADDR_W-1 -: TAG_W];

  assign accept     = req_valid && req_ready && (state == IDLE);
  assign misaligned = (req_addr[1:0] != 2'b00);
  // A same-cycle inval clears the array first, so the lookup must miss.
  assign hit        = lk_valid && (lk_tag == req_tag) && !inval;

  assign wr_en     = (state == MWAIT) && mem_resp_valid;
  assign tag_wr_en = wr_en && (beat_cnt == LAST_BEAT);
  assign clr_all   = ((state == IDLE) && inval) ||
                     ((state == RESP) && (inval_pend || inval));

  always_comb begin
    rd_en    = 1'b0;
    rd_index = req_idx;
    rd_word  = req_word;
    if (accept && !misaligned && hit) rd_en = 1'b1;
    if (state == RESP) begin
      rd_en    = 1'b1;
      rd_index = pend_idx;
      rd_word  = pend_word;
    end
  end

  icache_line_store #(
    .LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .WRD_W(WRD_W)
  ) u_store (
    .clk(clk), .rst(rst),
    .lk_index(req_idx), .lk_valid(lk_valid), .lk_tag(lk_tag),
    .rd_en(rd_en), .rd_index(rd_index), .rd_word(rd_word), .rd_data(rd_data),
    .wr_en(wr_en), .wr_index(pend_idx), .wr_word(beat_cnt), .wr_data(mem_resp_data),
    .tag_wr_en(tag_wr_en), .tag_wr(pend_tag), .clr_all(clr_all)
  );

  always_ff @(posedge clk) begin
    if (accept) pend_addr <= req_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      resp_valid_p1 <= 1'b0;
      use_rd_p1     <= 1'b0;
      resp_addr     <= '0;
      resp_err      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      beat_cnt      <= '0;
      flushed       <= 1'b0;
      inval_pend    <= 1'b0;
    end else begin
      resp_valid_p1 <= 1'b0;
      if (state != IDLE && flush) flushed    <= 1'b1;
      if (state != IDLE && inval) inval_pend <= 1'b1;
      case (state)
        IDLE: begin
          req_ready  <= 1'b1;
          inval_pend <= 1'b0;
          if (accept) begin
            flushed <= 1'b0;
            if (misaligned || hit) begin
              resp_valid_p1 <= 1'b1;
              resp_err      <= misaligned;
              use_rd_p1     <= !misaligned;
              resp_addr     <= req_addr;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              req_ready     <= 1'b0;
              state         <= MREQ;
            end
          end
        end
        MREQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat_cnt      <= '0;
            state         <= MWAIT;
          end
        end
        MWAIT: begin
          if (mem_resp_valid) begin
            beat_cnt <= beat_cnt + WRD_W'(1);
            if (beat_cnt == LAST_BEAT) state <= RESP;
          end
        end
        RESP: begin
          if (!(flushed || flush)) begin
            resp_valid_p1 <= 1'b1;
            resp_err      <= 1'b0;
            use_rd_p1     <= 1'b1;
            resp_addr     <= pend_addr;
          end
          flushed    <= 1'b0;
          inval_pend <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response stage: a redirect in the response cycle squashes the older answer.
  assign resp_valid = resp_valid_p1 && !flush;
  assign resp_instr = use_rd_p1 ? rd_data : NOP;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: hits, misses, conflicts, misalignment,
// flush, invalidate and reset during refill.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, flush, inval;
  logic [31:0] req_addr;
  logic        resp_valid, resp_err;
  logic [31:0] resp_instr, resp_addr;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .inval(inval),
    .resp_valid(resp_valid), .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] a, input logic fl, input logic iv);
    req_valid = 1'b1; req_addr = a; flush = fl; inval = iv;
    step();
    req_valid = 1'b0; flush = 1'b0; inval = 1'b0;
    #1;
  endtask

  task automatic serve_refill(input logic [31:0] base);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = base + 32'(i);
      step();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; inval = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0d expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_vld: got %0d expected 0", resp_valid); end
    checks++; if (resp_instr !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h expected 00000013", resp_instr); end
    checks++; if (resp_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", resp_addr); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0d expected 0", resp_err); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mreq: got %0d expected 0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_maddr: got %h expected 0", mem_req_addr); end
    rst = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0d expected 1", req_ready); end
  endtask

  task automatic test_cold_miss();
    send_req(32'h100, 1'b0, 1'b0);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL cold_mreq: got %0d expected 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL cold_maddr: got %h expected 00000100", mem_req_addr); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL cold_ready: got %0d expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL cold_early_vld: got %0d expected 0", resp_valid); end
    serve_refill(32'hA0);
    step();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL cold_vld: got %0d expected 1", resp_valid); end
    checks++; if (resp_instr !== 32'hA0) begin errors++; $display("FAIL cold_instr: got %h expected 000000a0", resp_instr); end
    checks++; if (resp_addr !== 32'h100) begin errors++; $display("FAIL cold_addr: got %h expected 00000100", resp_addr); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL cold_err: got %0d expected 0", resp_err); end
    send_req(32'h104, 1'b0, 1'b0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hit104_vld: got %0d expected 1", resp_valid); end
    checks++; if (resp_instr !== 32'hA1) begin errors++; $display("FAIL hit104_instr: got %h expected 000000a1", resp_instr); end
    checks++; if (resp_addr !== 32'h104) begin errors++; $display("FAIL hit104_addr: got %h expected 00000104", resp_addr); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL hit104_mreq: got %0d expected 0", mem_req_valid); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_addr = 32'h108;
    step();
    req_addr = 32'h10C;
    checks++; if (resp_instr !== 32'hA2) begin errors++; $display("FAIL b2b_instr0: got %h expected 000000a2", resp_instr); end
    checks++; if (resp_addr !== 32'h108) begin errors++; $display("FAIL b2b_addr0: got %h expected 00000108", resp_addr); end
    step();
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_vld1: got %0d expected 1", resp_valid); end
    checks++; if (resp_instr !== 32'hA3) begin errors++; $display("FAIL b2b_instr1: got %h expected 000000a3", resp_instr); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %0d expected 0", resp_valid); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_mreq: got %0d expected 0", mem_req_valid); end
  endtask

  task automatic test_conflict();
    send_req(32'h200, 1'b0, 1'b0);
    checks++; if (mem_req_addr !== 32'h200) begin errors++; $display("FAIL conf_maddr: got %h expected 00000200", mem_req_addr); end
    serve_refill(32'hB0);
    step();
    checks++; if (resp_instr !== 32'hB0) begin errors++; $display("FAIL conf_instr: got %h expected 000000b0", resp_instr); end
    send_req(32'h100, 1'b0, 1'b0);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL conf_evict_mreq: got %0d expected 1", mem_req_valid); end
    serve_refill(32'hA0);
    step();
    checks++; if (resp_instr !== 32'hA0) begin errors++; $display("FAIL conf_refill_instr: got %h expected 000000a0", resp_instr); end
  endtask

  task automatic test_misaligned();
    send_req(32'h102, 1'b0, 1'b0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL mis_vld: got %0d expected 1", resp_valid); end
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %0d expected 1", resp_err); end
    checks++; if (resp_instr !== 32'h13) begin errors++; $display("FAIL mis_instr: got %h expected 00000013", resp_instr); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_mreq: got %0d expected 0", mem_req_valid); end
    step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_mreq_late: got %0d expected 0", mem_req_valid); end
    send_req(32'h100, 1'b0, 1'b0);
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL mis_err_clear: got %0d expected 0", resp_err); end
  endtask

  task automatic test_flush();
    int seen;
    send_req(32'h300, 1'b0, 1'b0);
    checks++; if (mem_req_addr !== 32'h300) begin errors++; $display("FAIL fl_maddr: got %h expected 00000300", mem_req_addr); end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hC0 + 32'(i); flush = (i == 1);
      step();
    end
    mem_resp_valid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (resp_valid) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL fl_suppressed: got %0d responses expected 0", seen); end
    send_req(32'h304, 1'b1, 1'b0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL fl_target_vld: got %0d expected 1", resp_valid); end
    checks++; if (resp_instr !== 32'hC1) begin errors++; $display("FAIL fl_target_instr: got %h expected 000000c1", resp_instr); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fl_target_mreq: got %0d expected 0", mem_req_valid); end
    req_valid = 1'b1; req_addr = 32'h308;
    step();
    req_valid = 1'b0; flush = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL fl_hit_squash: got %0d expected 0", resp_valid); end
    flush = 1'b0;
    step();
  endtask

  task automatic test_inval();
    send_req(32'h100, 1'b0, 1'b0);
    serve_refill(32'hA0);
    step();
    inval = 1'b1;
    step();
    inval = 1'b0;
    send_req(32'h100, 1'b0, 1'b0);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL inv_idle_mreq: got %0d expected 1", mem_req_valid); end
    serve_refill(32'hA0);
    step();
    checks++; if (resp_instr !== 32'hA0) begin errors++; $display("FAIL inv_idle_instr: got %h expected 000000a0", resp_instr); end
    send_req(32'h104, 1'b0, 1'b1);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL inv_same_mreq: got %0d expected 1", mem_req_valid); end
    serve_refill(32'hA0);
    step();
    checks++; if (resp_instr !== 32'hA1) begin errors++; $display("FAIL inv_same_instr: got %h expected 000000a1", resp_instr); end
    send_req(32'h214, 1'b0, 1'b0);
    checks++; if (mem_req_addr !== 32'h210) begin errors++; $display("FAIL inv_mreq_align: got %h expected 00000210", mem_req_addr); end
    inval = 1'b1;
    step();
    inval = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL inv_mreq_hold: got %0d expected 1", mem_req_valid); end
    serve_refill(32'hD0);
    step();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL inv_mreq_vld: got %0d expected 1", resp_valid); end
    checks++; if (resp_instr !== 32'hD1) begin errors++; $display("FAIL inv_mreq_instr: got %h expected 000000d1", resp_instr); end
    send_req(32'h214, 1'b0, 1'b0);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL inv_fill_cleared: got %0d expected 1", mem_req_valid); end
    serve_refill(32'hD0);
    step();
    send_req(32'h100, 1'b0, 1'b0);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL inv_100_cleared: got %0d expected 1", mem_req_valid); end
    serve_refill(32'hA0);
    step();
    checks++; if (resp_instr !== 32'hA0) begin errors++; $display("FAIL inv_100_instr: got %h expected 000000a0", resp_instr); end
  endtask

  task automatic test_reset_mid_refill();
    send_req(32'h400, 1'b0, 1'b0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hE0 + 32'(i);
      step();
    end
    mem_resp_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_mreq: got %0d expected 0", mem_req_valid); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %0d expected 0", resp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0d expected 0", req_ready); end
    step();
    rst = 1'b1;
    step();
    send_req(32'h100, 1'b0, 1'b0);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_100_miss: got %0d expected 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL mid_rst_maddr: got %h expected 00000100", mem_req_addr); end
    serve_refill(32'hA0);
    step();
    checks++; if (resp_instr !== 32'hA0) begin errors++; $display("FAIL mid_rst_instr: got %h expected 000000a0", resp_instr); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_misaligned();
    test_flush();
    test_inval();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
